event_write_arbiter: RTL and testbench

Shares the single 64-bit event FIFO write port among `N_SRC` event capture channels, each of which buffers a complete 16-word event frame. A round-robin FSM grants one channel at a time. For each granted channel it writes one header word (source id plus global event number), then drains the channel's `BURST_LEN` data words, honouring FIFO back-pressure. The block sits between the per-channel capture/save logic and the readout FIFO, and is the only writer of that FIFO.

---
 rtl/event_write_arbiter.sv | 133 +++++++++++++
 tb/tb_event_write_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/event_write_arbiter.sv
// event_write_arbiter
//   Round-robin owner of the readout FIFO write port. Each granted channel
//   produces one header word (0xE5E5, source id, global event number) and
//   then BURST_LEN data words. FIFO back-pressure is honoured word by word.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   req_i       per-channel "complete frame buffered" request
//   src_data_i  current frame word of each channel
//   take_o      one-hot, source word consumed at this edge
//   grant_o     one-hot, registered, channel owning the port
//   done_o      one-cycle pulse, frame of that channel fully written
//   full_i      FIFO full, suppresses any write in that cycle
//   wr_en_o     FIFO write strobe
//   din_o       FIFO write data (zero when not writing)
//   evt_cnt_o   frames completed since reset (wrapping)
module event_write_arbiter #(
  parameter int N_SRC     = 4,
  parameter int BURST_LEN = 16,
  parameter int DATA_W    = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [N_SRC-1:0]               req_i,
  input  logic [N_SRC-1:0][DATA_W-1:0]   src_data_i,
  output logic [N_SRC-1:0]               take_o,
  output logic [N_SRC-1:0]               grant_o,
  output logic [N_SRC-1:0]               done_o,
  input  logic                           full_i,
  output logic                           wr_en_o,
  output logic [DATA_W-1:0]              din_o,
  output logic [31:0]                    evt_cnt_o
);

  localparam int GW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int BW = $clog2(BURST_LEN);

  typedef enum logic [1:0] {IDLE, HEADER, BURST, RELEASE} state_t;

  state_t          state;
  logic [GW-1:0]   g;
  logic [GW-1:0]   last;
  logic [BW-1:0]   beat;
  logic [31:0]     evt_cnt;
  logic [N_SRC-1:0] grant_r;

  logic [GW-1:0]   pick;
  logic            found;
  logic [GW-1:0]   j_idx;

  // Circular search starting just above the last served channel.
  always_comb begin
    pick  = last;
    found = 1'b0;
    j_idx = '0;
    for (int unsigned i = 1; i <= N_SRC; i++) begin
      j_idx = GW'((32'(last) + i) % N_SRC);
      if (!found && req_i[j_idx]) begin
        found = 1'b1;
        pick  = j_idx;
      end
    end
  end

  always_comb begin
    wr_en_o = 1'b0;
    din_o   = '0;
    take_o  = '0;
    done_o  = '0;
    case (state)
      HEADER: begin
        if (!full_i) begin
          wr_en_o = 1'b1;
          din_o   = {16'hE5E5, 8'(g), 8'd0, evt_cnt};
        end
      end
      BURST: begin
        if (!full_i) begin
          wr_en_o   = 1'b1;
          din_o     = src_data_i[g];
          take_o[g] = 1'b1;
        end
      end
      RELEASE: done_o[g] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      grant_r <= '0;
      beat    <= '0;
      g       <= '0;
      last    <= GW'(N_SRC - 1);
      evt_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_i) begin
            g       <= pick;
            grant_r <= {{(N_SRC-1){1'b0}}, 1'b1} << pick;
            state   <= HEADER;
          end
        end
        HEADER: begin
          if (!full_i) begin
            beat  <= '0;
            state <= BURST;
          end
        end
        BURST: begin
          if (!full_i) begin
            beat <= beat + 1'b1;
            if (beat == BW'(BURST_LEN - 1)) state <= RELEASE;
          end
        end
        RELEASE: begin
          last    <= g;
          evt_cnt <= evt_cnt + 32'd1;
          grant_r <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign grant_o   = grant_r;
  assign evt_cnt_o = evt_cnt;

endmodule

// File: tb/tb_event_write_arbiter.sv
module tb_event_write_arbiter;
  localparam int N  = 4;
  localparam int BL = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  reset;
  logic [N-1:0]          req_i, take_o, grant_o, done_o;
  logic [N-1:0][63:0]    src_data_i;
  logic                  full_i, wr_en_o;
  logic [63:0]           din_o;
  logic [31:0]           evt_cnt_o;

  // Second instance: short frames, used for the event-count wrap.
  logic [1:0]            w_req, w_take, w_grant, w_done;
  logic [1:0][63:0]      w_src;
  logic                  w_full, w_wr;
  logic [63:0]           w_din;
  logic [31:0]           w_cnt;

  event_write_arbiter #(.N_SRC(N), .BURST_LEN(BL), .DATA_W(64)) dut (
    .clk(clk), .reset(reset), .req_i(req_i), .src_data_i(src_data_i),
    .take_o(take_o), .grant_o(grant_o), .done_o(done_o), .full_i(full_i),
    .wr_en_o(wr_en_o), .din_o(din_o), .evt_cnt_o(evt_cnt_o)
  );

  event_write_arbiter #(.N_SRC(2), .BURST_LEN(2), .DATA_W(64)) u_w (
    .clk(clk), .reset(reset), .req_i(w_req), .src_data_i(w_src),
    .take_o(w_take), .grant_o(w_grant), .done_o(w_done), .full_i(w_full),
    .wr_en_o(w_wr), .din_o(w_din), .evt_cnt_o(w_cnt)
  );

  int tests = 0;
  int fails = 0;
  int viol_full = 0, viol_din = 0, viol_grant = 0;

  logic [N-1:0] want, req_r;
  int           ptr [N];
  logic         s_wr;
  logic [63:0]  s_din;
  logic [N-1:0] s_take, s_done, s_grant;

  typedef struct {
    logic [N-1:0] want;
    logic [N-1:0] want_mid;
    int           ch;
    logic [31:0]  cnt;
    int           hstall;
    bit           estall;
  } vec_t;

  vec_t vt [13];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clock cycle: drive at negedge, sample outputs, then update requesters.
  task automatic cyc(input logic f);
    @(negedge clk);
    full_i = f;
    req_i  = req_r & want;
    for (int k = 0; k < N; k++) src_data_i[k] = {8'(k), 24'h0, 32'(ptr[k])};
    #1;
    s_wr = wr_en_o; s_din = din_o; s_take = take_o; s_done = done_o; s_grant = grant_o;
    if (f && (s_wr || s_take != '0)) viol_full++;
    if (!s_wr && s_din != '0) viol_din++;
    if (!$onehot0(s_grant)) viol_grant++;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (s_take[k]) ptr[k]++;
      if (s_done[k]) begin
        req_r[k] = 1'b0;
        ptr[k]   = 0;
      end else begin
        req_r[k] = want[k];
      end
      if (reset) ptr[k] = 0;
    end
  endtask

  task automatic run_vec(input vec_t t);
    int n, beat, writes;
    bit st;
    logic [N-1:0] eg;
    want = t.want;
    n = 0;
    while (grant_o == '0 && n < 40) begin
      cyc(1'b0);
      n++;
    end
    eg = N'(1) << t.ch;
    check("grant", grant_o, eg);
    want = t.want_mid;
    writes = 0;
    for (int i = 0; i < t.hstall; i++) cyc(1'b1);
    cyc(1'b0);
    writes += int'(s_wr);
    check("header", s_din, {16'hE5E5, 8'(t.ch), 8'h00, t.cnt});
    beat = 0;
    st = 0;
    while (beat < BL) begin
      if (t.estall && (beat % 2 == 0) && !st) begin
        cyc(1'b1);
        st = 1;
      end else begin
        cyc(1'b0);
        st = 0;
        writes += int'(s_wr);
        check("data", s_din, {8'(t.ch), 24'h0, 32'(beat)});
        check("take", s_take, eg);
        beat++;
      end
    end
    cyc(1'b0);
    check("done", s_done, eg);
    check("writes", writes, BL + 1);
    check("evt_cnt", evt_cnt_o, t.cnt + 32'd1);
  endtask

  task automatic wframe(output logic [63:0] hdr, output int nw);
    bit got;
    nw = 0; hdr = '0; got = 0;
    w_req = 2'b01;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      #1;
      if (w_wr) begin
        if (nw == 0) hdr = w_din;
        nw++;
      end
      if (w_done[0]) got = 1;
      @(posedge clk);
      #1;
      if (got) w_req = 2'b00;
    end
    check("wrap_done", got, 1);
  endtask

  initial begin
    logic [63:0] h;
    int nw, n;

    vt[0]  = '{4'b0001, 4'b0001, 0, 32'd0,  0, 1'b0};
    vt[1]  = '{4'b1111, 4'b1111, 1, 32'd1,  0, 1'b0};
    vt[2]  = '{4'b1111, 4'b1111, 2, 32'd2,  0, 1'b0};
    vt[3]  = '{4'b1111, 4'b1111, 3, 32'd3,  0, 1'b0};
    vt[4]  = '{4'b1111, 4'b1111, 0, 32'd4,  0, 1'b0};
    vt[5]  = '{4'b1111, 4'b1111, 1, 32'd5,  0, 1'b0};
    vt[6]  = '{4'b1111, 4'b1111, 2, 32'd6,  3, 1'b1};
    vt[7]  = '{4'b0100, 4'b0110, 2, 32'd7,  0, 1'b0};
    vt[8]  = '{4'b0110, 4'b0110, 1, 32'd8,  0, 1'b0};
    vt[9]  = '{4'b0110, 4'b0110, 2, 32'd9,  0, 1'b0};
    vt[10] = '{4'b0010, 4'b0010, 1, 32'd10, 0, 1'b0};
    vt[11] = '{4'b0110, 4'b0110, 1, 32'd0,  0, 1'b0};
    vt[12] = '{4'b0110, 4'b0110, 2, 32'd1,  0, 1'b0};

    reset = 1'b1; want = '0; req_r = '0; full_i = 1'b0; req_i = '0;
    src_data_i = '0; w_req = '0; w_full = 1'b0;
    w_src[0] = 64'hA0; w_src[1] = 64'hB1;
    for (int k = 0; k < N; k++) ptr[k] = 0;
    cyc(1'b0);
    cyc(1'b0);
    reset = 1'b0;
    cyc(1'b1);
    check("rst_grant", s_grant, '0);
    check("rst_wr", s_wr, 0);
    check("rst_din", s_din, '0);
    check("rst_done", s_done, '0);
    check("rst_cnt", evt_cnt_o, 0);

    for (int i = 0; i <= 10; i++) run_vec(vt[i]);

    // Reset during beat 7 of channel 1's frame.
    want = 4'b0010;
    n = 0;
    while (grant_o == '0 && n < 40) begin
      cyc(1'b0);
      n++;
    end
    check("mid_grant", grant_o, 4'b0010);
    cyc(1'b0);
    for (int b = 0; b < 7; b++) cyc(1'b0);
    check("mid_beat6", s_din, {8'd1, 24'h0, 32'd6});
    want = '0;
    reset = 1'b1;
    cyc(1'b0);
    reset = 1'b0;
    cyc(1'b0);
    check("mid_rst_grant", s_grant, '0);
    check("mid_rst_wr", s_wr, 0);
    check("mid_rst_din", s_din, '0);
    check("mid_rst_take", s_take, '0);
    check("mid_rst_done", s_done, '0);
    check("mid_rst_cnt", evt_cnt_o, 0);

    for (int i = 11; i <= 12; i++) run_vec(vt[i]);

    // Count wrap on the short-frame instance.
    @(negedge clk);
    force u_w.evt_cnt = 32'hFFFF_FFFF;
    @(negedge clk);
    release u_w.evt_cnt;
    #1;
    check("wrap_preload", w_cnt, 32'hFFFF_FFFF);
    wframe(h, nw);
    check("wrap_hdr_max", h, {16'hE5E5, 8'h00, 8'h00, 32'hFFFF_FFFF});
    check("wrap_words", nw, 3);
    check("wrap_cnt_zero", w_cnt, 0);
    @(posedge clk); #1;
    wframe(h, nw);
    check("wrap_hdr_zero", h, {16'hE5E5, 8'h00, 8'h00, 32'h0});
    check("wrap_cnt_one", w_cnt, 1);

    check("no_write_while_full", viol_full, 0);
    check("din_zero_when_idle", viol_din, 0);
    check("grant_onehot", viol_grant, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
